// File: rtl/dvi_encoder_pkg.sv
// Shared constants, disparity type and helpers for the DVI TMDS encoder.
// The DVI_INPUT_REG_EN macro selects the extra input register stage (latency 3 instead of 2).
package dvi_encoder_pkg;

    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

`ifdef DVI_INPUT_REG_EN
    localparam int LATENCY = 3;
`else
    localparam int LATENCY = 2;
`endif

    // Running disparity; the algorithm keeps it within +/-10.
    typedef logic signed [4:0] disp_t;

    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
        logic [9:0] t;
        case ({c1, c0})
            2'b00:   t = CTRL_00;
            2'b01:   t = CTRL_01;
            2'b10:   t = CTRL_10;
            default: t = CTRL_11;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/dvi_encoder_tmds_channel.sv
// One TMDS channel: stage 1 transition-minimising q_m, stage 2 DC balance or control token.
module tmds_channel
    import dvi_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] d,
    input  logic       de,
    input  logic       c1,
    input  logic       c0,
    output logic [9:0] q
);

    logic [3:0] n1_d;
    logic       use_xnor;
    logic [8:0] qm_next;

    logic [8:0] qm;
    logic       de_s1;
    logic       c1_s1;
    logic       c0_s1;

    disp_t      cnt;
    disp_t      cnt_next;
    logic [9:0] q_next;
    logic [3:0] n1;
    logic [3:0] n0;
    disp_t      diff;

    always_comb begin
        logic prev;
        n1_d     = count_ones(d);
        use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && (d[0] == 1'b0));
        qm_next  = '0;
        prev     = d[0];
        qm_next[0] = prev;
        for (int i = 1; i < 8; i++) begin
            prev       = use_xnor ? ~(prev ^ d[i]) : (prev ^ d[i]);
            qm_next[i] = prev;
        end
        qm_next[8] = ~use_xnor;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qm    <= '0;
            de_s1 <= 1'b0;
            c1_s1 <= 1'b0;
            c0_s1 <= 1'b0;
        end else begin
            qm    <= qm_next;
            de_s1 <= de;
            c1_s1 <= c1;
            c0_s1 <= c0;
        end
    end

    // diff = N1 - N0 over q_m[7:0], range -8..8.
    always_comb begin
        n1       = count_ones(qm[7:0]);
        n0       = 4'd8 - n1;
        diff     = disp_t'({1'b0, n1}) - disp_t'({1'b0, n0});
        q_next   = '0;
        cnt_next = cnt;
        if (!de_s1) begin
            q_next   = ctrl_token(c1_s1, c0_s1);
            cnt_next = '0;
        end else if ((cnt == 5'sd0) || (n1 == n0)) begin
            q_next   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_next = qm[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 5'sd0) && (n1 > n0)) || ((cnt < 5'sd0) && (n0 > n1))) begin
            q_next   = {1'b1, qm[8], ~qm[7:0]};
            cnt_next = cnt + (qm[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            q_next   = {1'b0, qm[8], qm[7:0]};
            cnt_next = cnt - (qm[8] ? 5'sd0 : 5'sd2) + diff;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q   <= CTRL_00;
            cnt <= '0;
        end else begin
            q   <= q_next;
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/dvi_encoder.sv
// DVI encoder top: nibble expansion, sync routing and three TMDS channels.
// Define DVI_INPUT_REG_EN to register all inputs ahead of the encoder (latency 3).
module dvi_encoder
    import dvi_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] vga_r,
    input  logic [3:0] vga_g,
    input  logic [3:0] vga_b,
    input  logic       vga_hs,
    input  logic       vga_vs,
    input  logic       active,
    output logic [9:0] tmds_ch0,
    output logic [9:0] tmds_ch1,
    output logic [9:0] tmds_ch2
);

    logic [3:0] r_s;
    logic [3:0] g_s;
    logic [3:0] b_s;
    logic       hs_s;
    logic       vs_s;
    logic       de_s;

`ifdef DVI_INPUT_REG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s  <= '0;
            g_s  <= '0;
            b_s  <= '0;
            hs_s <= 1'b0;
            vs_s <= 1'b0;
            de_s <= 1'b0;
        end else begin
            r_s  <= vga_r;
            g_s  <= vga_g;
            b_s  <= vga_b;
            hs_s <= vga_hs;
            vs_s <= vga_vs;
            de_s <= active;
        end
    end
`else
    always_comb begin
        r_s  = vga_r;
        g_s  = vga_g;
        b_s  = vga_b;
        hs_s = vga_hs;
        vs_s = vga_vs;
        de_s = active;
    end
`endif

    // Syncs ride on the blue channel only; green and red send token 00 in blanking.
    tmds_channel u_ch0 (
        .clk   (clk),
        .reset (reset),
        .d     ({b_s, b_s}),
        .de    (de_s),
        .c1    (vs_s),
        .c0    (hs_s),
        .q     (tmds_ch0)
    );

    tmds_channel u_ch1 (
        .clk   (clk),
        .reset (reset),
        .d     ({g_s, g_s}),
        .de    (de_s),
        .c1    (1'b0),
        .c0    (1'b0),
        .q     (tmds_ch1)
    );

    tmds_channel u_ch2 (
        .clk   (clk),
        .reset (reset),
        .d     ({r_s, r_s}),
        .de    (de_s),
        .c1    (1'b0),
        .c0    (1'b0),
        .q     (tmds_ch2)
    );

endmodule

// File: tb/tb_dvi_encoder.sv
// Self-checking bench for dvi_encoder: directed steps plus random lines against an integer reference model.
// Works in both builds; latency follows dvi_encoder_pkg::LATENCY (DVI_INPUT_REG_EN).
module tb_dvi_encoder;

    localparam int L = dvi_encoder_pkg::LATENCY;

    logic       clk;
    logic       reset;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       active;
    logic [9:0] tmds_ch0;
    logic [9:0] tmds_ch1;
    logic [9:0] tmds_ch2;

    dvi_encoder dut (
        .clk      (clk),
        .reset    (reset),
        .vga_r    (vga_r),
        .vga_g    (vga_g),
        .vga_b    (vga_b),
        .vga_hs   (vga_hs),
        .vga_vs   (vga_vs),
        .active   (active),
        .tmds_ch0 (tmds_ch0),
        .tmds_ch1 (tmds_ch1),
        .tmds_ch2 (tmds_ch2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] q0;
        logic [9:0] q1;
        logic [9:0] q2;
        int         c0;
        int         c1;
        int         c2;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] obs0[$];
    logic [9:0] obs1[$];
    logic [9:0] obs2[$];
    int         obsc0[$];
    int         obsc1[$];
    int         obsc2[$];
    int         cnt_m[3];
    int         n_cmp = 0;
    int         n_err = 0;

    // ---------------- reference model (integer arithmetic on the encoding rules) ----------------
    function automatic int popc8(input int v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += (v >> i) & 1;
        return n;
    endfunction

    function automatic int token(input int c);
        case (c)
            0: return 'h354;
            1: return 'h0AB;
            2: return 'h154;
            default: return 'h2AB;
        endcase
    endfunction

    function automatic int encode(input int ch, input int d, input int de, input int c);
        int ones_d, inv, qm, b, qm8, n1, n0, res;
        if (de == 0) begin
            cnt_m[ch] = 0;
            return token(c);
        end
        ones_d = popc8(d);
        inv = (ones_d > 4 || (ones_d == 4 && (d & 1) == 0)) ? 1 : 0;
        qm = d & 1;
        for (int i = 1; i < 8; i++) begin
            b = ((qm >> (i - 1)) ^ (d >> i)) & 1;
            if (inv == 1) b = b ^ 1;
            qm = qm | (b << i);
        end
        qm8 = 1 - inv;
        n1 = popc8(qm);
        n0 = 8 - n1;
        if (cnt_m[ch] == 0 || n1 == n0) begin
            if (qm8 == 1) begin
                res = 'h100 | qm;
                cnt_m[ch] += n1 - n0;
            end else begin
                res = 'h200 | (~qm & 'hFF);
                cnt_m[ch] += n0 - n1;
            end
        end else if ((cnt_m[ch] > 0 && n1 > n0) || (cnt_m[ch] < 0 && n0 > n1)) begin
            res = 'h200 | (qm8 << 8) | (~qm & 'hFF);
            cnt_m[ch] += 2 * qm8 + n0 - n1;
        end else begin
            res = (qm8 << 8) | qm;
            cnt_m[ch] += -2 * (1 - qm8) + n1 - n0;
        end
        return res;
    endfunction

    // ---------------- checkers ----------------
    task automatic check_sym(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_bound(input string tag, input int obs);
        n_cmp++;
        assert (obs >= -10 && obs <= 10) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=-10..10", tag, obs);
        end
    endtask

    task automatic record_obs();
        obs0.push_back(tmds_ch0);
        obs1.push_back(tmds_ch1);
        obs2.push_back(tmds_ch2);
        obsc0.push_back(int'(dut.u_ch0.cnt));
        obsc1.push_back(int'(dut.u_ch1.cnt));
        obsc2.push_back(int'(dut.u_ch2.cnt));
    endtask

    // ---------------- drivers ----------------
    task automatic step(input int r, input int g, input int b, input int hs, input int vs, input int act);
        exp_t e;
        exp_t cur;
        vga_r  = 4'(r);
        vga_g  = 4'(g);
        vga_b  = 4'(b);
        vga_hs = 1'(hs);
        vga_vs = 1'(vs);
        active = 1'(act);
        e.q0 = 10'(encode(0, b * 17, act, vs * 2 + hs));
        e.c0 = cnt_m[0];
        e.q1 = 10'(encode(1, g * 17, act, 0));
        e.c1 = cnt_m[1];
        e.q2 = 10'(encode(2, r * 17, act, 0));
        e.c2 = cnt_m[2];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cur = exp_q.pop_front();
        record_obs();
        check_sym("ch0_sym", tmds_ch0, cur.q0);
        check_sym("ch1_sym", tmds_ch1, cur.q1);
        check_sym("ch2_sym", tmds_ch2, cur.q2);
        check_cnt("ch0_cnt", int'(dut.u_ch0.cnt), cur.c0);
        check_cnt("ch1_cnt", int'(dut.u_ch1.cnt), cur.c1);
        check_cnt("ch2_cnt", int'(dut.u_ch2.cnt), cur.c2);
        check_bound("ch0_cnt_range", int'(dut.u_ch0.cnt));
    endtask

    task automatic do_reset(input int cycles);
        exp_t t;
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            record_obs();
            check_sym("reset_ch0", tmds_ch0, 10'h354);
            check_sym("reset_ch1", tmds_ch1, 10'h354);
            check_sym("reset_ch2", tmds_ch2, 10'h354);
            check_cnt("reset_cnt", int'(dut.u_ch0.cnt), 0);
        end
        reset = 1'b0;
        exp_q.delete();
        for (int ch = 0; ch < 3; ch++) cnt_m[ch] = 0;
        t = '{q0: 10'h354, q1: 10'h354, q2: 10'h354, c0: 0, c1: 0, c2: 0};
        for (int i = 0; i < L - 1; i++) exp_q.push_back(t);
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        int idx;
        reset  = 1'b1;
        vga_r  = '0;
        vga_g  = '0;
        vga_b  = '0;
        vga_hs = 1'b0;
        vga_vs = 1'b0;
        active = 1'b0;
        for (int ch = 0; ch < 3; ch++) cnt_m[ch] = 0;

        do_reset(3);

        // Blanking after release: hs low, vs high -> ch0 token 10.
        for (int i = 0; i < L + 1; i++) step(0, 0, 0, 0, 1, 0);
        check_sym("blank_hs0_vs1_ch0", obs0[obs0.size() - 1], 10'h154);
        check_sym("blank_hs0_vs1_ch1", obs1[obs1.size() - 1], 10'h354);
        check_sym("blank_hs0_vs1_ch2", obs2[obs2.size() - 1], 10'h354);

        // All-zero pixels from cnt = 0.
        idx = obs0.size();
        step(0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 1, 1);
        for (int i = 0; i < L; i++) step(0, 0, 0, 1, 1, 0);
        check_sym("zero_first_sym", obs0[idx + L - 1], 10'h100);
        check_cnt("zero_first_cnt", obsc0[idx + L - 1], -8);
        check_sym("zero_second_sym", obs2[idx + L], 10'h3FF);
        check_cnt("zero_second_cnt", obsc2[idx + L], 2);
        check_sym("fall_edge_token", obs0[idx + L + 1], 10'h2AB);
        check_cnt("fall_edge_cnt", obsc0[idx + L + 1], 0);

        // All-ones pixels from cnt = 0.
        idx = obs0.size();
        step(15, 15, 15, 1, 1, 1);
        for (int i = 0; i < L; i++) step(0, 0, 0, 1, 1, 0);
        check_sym("ones_first_sym", obs1[idx + L - 1], 10'h200);
        check_cnt("ones_first_cnt", obsc1[idx + L - 1], -8);

        // Single-cycle active pulse with a data change, then an hs pulse in blanking.
        idx = obs0.size();
        step(5, 10, 3, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < L; i++) step(0, 0, 0, 1, 1, 0);
        check_sym("pulse_pre_token", obs0[idx + L - 2], 10'h2AB);
        check_sym("pulse_data_ch1", obs1[idx + L - 1], 10'h233);
        check_sym("pulse_hs_token", obs0[idx + L], 10'h154);
        check_sym("pulse_post_token", obs0[idx + L + 1], 10'h2AB);

        // 512-pixel random line, then blanking must leave cnt = 0.
        for (int i = 0; i < 512; i++)
            step($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1, 1, 1);
        for (int i = 0; i < L + 2; i++) step(0, 0, 0, 1, 1, 0);
        check_cnt("line_end_cnt0", obsc0[obsc0.size() - 1], 0);
        check_cnt("line_end_cnt1", obsc1[obsc1.size() - 1], 0);
        check_cnt("line_end_cnt2", obsc2[obsc2.size() - 1], 0);

        // Random activity with toggling active and syncs.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) != 0) ? 1 : 0);

        // Mid-line reset for one cycle, then resume with no residual disparity.
        for (int i = 0; i < 20; i++)
            step($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1, 1, 1);
        do_reset(1);
        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1, 1, 1);
        for (int i = 0; i < L + 1; i++) step(0, 0, 0, 1, 0, 0);
        check_sym("resume_blank_ch0", obs0[obs0.size() - 1], 10'h0AB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
